// File: rtl/mips16_loader_pkg.sv
// Shared types and constants for the MIPS16 instruction-memory loader.
package mips16_loader_pkg;

  localparam int WORD_W    = 16;
  localparam int HDR_BYTES = 2;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHK,
    S_RUN,
    S_ERR
  } state_t;

  function automatic logic is_load_state(state_t s);
    return (s != S_RUN) && (s != S_ERR);
  endfunction

endpackage

// File: rtl/mips16_imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the MIPS16 loader.
interface mips16_imem_loader_if #(
  parameter int ADDR_W = 8
);
  import mips16_loader_pkg::*;

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/mips16_imem_loader.sv
// Packs a length-prefixed big-endian byte stream into 16-bit words for IMEM and holds the core in reset until loaded.
// Optional trailing XOR checksum byte is enabled by defining MIPS16_LOADER_CHECKSUM_EN.
module mips16_imem_loader
  import mips16_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  mips16_imem_loader_if.slave bus,
  input  logic              reload,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef MIPS16_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_RUN;
`endif

  state_t            state, state_n;
  logic              accept;
  logic              last_word;
  logic              len_bad;
  logic [LEN_W-1:0]  len_full;
  logic [LEN_W-1:0]  len_q;
  logic [7:0]        hi_q;
  logic              rdy_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
`ifdef MIPS16_LOADER_CHECKSUM_EN
  logic [7:0]        acc_q;
`endif

  assign bus.in_ready   = rdy_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_LEN_HI;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = bus.in_valid && rdy_q;
    len_full  = {len_q[LEN_W-1:8], bus.in_data};
    len_bad   = int'(len_full) > DEPTH;
    last_word = (int'(word_cnt) + 1) == int'(len_q);
    case (state)
      S_LEN_HI:  if (accept) state_n = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_bad)              state_n = S_ERR;
          else if (len_full == '0)  state_n = S_END;
          else                      state_n = S_DATA_HI;
        end
      end
      S_DATA_HI: if (accept) state_n = S_DATA_LO;
      S_DATA_LO: if (accept) state_n = last_word ? S_END : S_DATA_HI;
`ifdef MIPS16_LOADER_CHECKSUM_EN
      S_CHK:     if (accept) state_n = ((acc_q ^ bus.in_data) == 8'h00) ? S_RUN : S_ERR;
`endif
      S_RUN, S_ERR: if (reload) state_n = S_LEN_HI;
      default:   state_n = S_LEN_HI;
    endcase
  end

  // Registered outputs follow the next state so flags change on the entering edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q     <= '0;
      hi_q      <= '0;
      word_cnt  <= '0;
      rdy_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_reset <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
`ifdef MIPS16_LOADER_CHECKSUM_EN
      acc_q     <= '0;
`endif
    end else begin
      we_q      <= 1'b0;
      rdy_q     <= is_load_state(state_n);
      cpu_reset <= (state_n != S_RUN);
      load_done <= (state_n == S_RUN);
      load_err  <= (state_n == S_ERR);
      if (accept) begin
        case (state)
          S_LEN_HI:  len_q[LEN_W-1:8] <= bus.in_data;
          S_LEN_LO:  len_q[7:0] <= bus.in_data;
          S_DATA_HI: hi_q <= bus.in_data;
          S_DATA_LO: begin
            we_q     <= 1'b1;
            addr_q   <= word_cnt[ADDR_W-1:0];
            wdata_q  <= {hi_q, bus.in_data};
            word_cnt <= word_cnt + (ADDR_W+1)'(1);
          end
          default: ;
        endcase
      end
`ifdef MIPS16_LOADER_CHECKSUM_EN
      if (accept && state != S_CHK) acc_q <= acc_q ^ bus.in_data;
`endif
      if (reload && (state == S_RUN || state == S_ERR)) begin
        word_cnt <= '0;
        len_q    <= '0;
`ifdef MIPS16_LOADER_CHECKSUM_EN
        acc_q    <= '0;
`endif
      end
    end
  end

endmodule
